// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus arbiter/sequencer.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_HOLD,
        D_SETUP,
        D_STROBE,
        D_HOLD,
        DONE
    } seq_state_e;

    localparam logic AD_ADDR   = 1'b0;
    localparam logic AD_DATA   = 1'b1;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width that stays legal for a count range of one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic seq_state_e next_phase(input seq_state_e s);
        case (s)
            A_SETUP:  return A_STROBE;
            A_STROBE: return A_HOLD;
            A_HOLD:   return D_SETUP;
            D_SETUP:  return D_STROBE;
            D_STROBE: return D_HOLD;
            D_HOLD:   return DONE;
            default:  return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rtc_arb_prio.sv
// Winner select over N requesters: fixed lowest-index priority or round-robin
// with a registered pointer that remembers the last accepted winner.
module rtc_arb_prio
    import rtc_bus_pkg::*;
#(
    parameter int N_CLIENTS = 4
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [N_CLIENTS-1:0] req_i,
    input  logic                 mode_i,
    input  logic                 accept_i,
    output logic [N_CLIENTS-1:0] winner_o,
    output logic                 valid_o
);

    localparam int                IDX_W   = cnt_width(N_CLIENTS);
    localparam logic [IDX_W-1:0]  PTR_RST = IDX_W'(N_CLIENTS - 1);

    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     win_idx;
    logic [N_CLIENTS-1:0] req_hi;
    logic [N_CLIENTS-1:0] cand;
    logic                 found;

    // Round-robin: prefer requesters above the pointer, else wrap to the lowest.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        req_hi = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            req_hi[i] = req_i[i] && (i > int'(ptr_q));
        end
        cand = ((mode_i == ARB_RR) && (|req_hi)) ? req_hi : req_i;

        win_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (!found && cand[i]) begin
                win_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    assign valid_o  = |req_i;
    assign winner_o = valid_o ? (N_CLIENTS'(1) << win_idx) : '0;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (Reset) begin
            ptr_q <= PTR_RST;
        end else if (accept_i && valid_o) begin
            ptr_q <= win_idx;
        end
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Serialises client transactions onto the multiplexed RTC bus and generates
// cs_n/rd_n/wr_n/ad strobes with T_PHASE-cycle setup, strobe and hold phases.
module rtc_bus_arbiter
    import rtc_bus_pkg::*;
#(
    parameter  int N_CLIENTS = 4,
    parameter  int ADDR_W    = 8,
    parameter  int DATA_W    = 8,
    parameter  int T_PHASE   = 4,
    parameter  int ARB_MODE  = 0,
    localparam int BUS_W     = max_int(ADDR_W, DATA_W)
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic [N_CLIENTS-1:0]        req_i,
    input  logic [N_CLIENTS-1:0]        rw_i,
    input  logic [N_CLIENTS*ADDR_W-1:0] addr_i,
    input  logic [N_CLIENTS*DATA_W-1:0] wdata_i,
    output logic [N_CLIENTS-1:0]        grant_o,
    output logic [N_CLIENTS-1:0]        done_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        busy_o,
    output logic                        cs_n_o,
    output logic                        rd_n_o,
    output logic                        wr_n_o,
    output logic                        ad_o,
    output logic [BUS_W-1:0]            bus_out_o,
    output logic                        bus_oe_o,
    input  logic [BUS_W-1:0]            bus_in_i
);

    localparam int               CNT_W    = cnt_width(T_PHASE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_PHASE - 1);
    localparam logic             ARB_SEL  = (ARB_MODE != 0) ? ARB_RR : ARB_FIXED;

    seq_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_CLIENTS-1:0] win_q, win_d;
    logic                 rw_q, rw_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic [N_CLIENTS-1:0] arb_win;
    logic                 arb_valid;
    logic                 accept;
    logic                 phase_end;
    logic                 sel_rw;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    assign accept = (state_q == IDLE) && arb_valid;

    rtc_arb_prio #(
        .N_CLIENTS (N_CLIENTS)
    ) u_arb (
        .clk      (clk),
        .Reset    (Reset),
        .req_i    (req_i),
        .mode_i   (ARB_SEL),
        .accept_i (accept),
        .winner_o (arb_win),
        .valid_o  (arb_valid)
    );

    // One-hot mux of the winning client's command fields.
    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (arb_win[i]) begin
                sel_rw    = sel_rw | rw_i[i];
                sel_addr  = sel_addr | addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign phase_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = A_SETUP;
                    cnt_d   = '0;
                    win_d   = arb_win;
                    rw_d    = sel_rw;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (phase_end) begin
                    state_d = next_phase(state_q);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Sample read data at the end of the strobe, just before rd_n rises.
                if ((state_q == D_STROBE) && phase_end && rw_q) begin
                    rdata_d = bus_in_i[DATA_W-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        cs_n_o    = 1'b1;
        rd_n_o    = 1'b1;
        wr_n_o    = 1'b1;
        ad_o      = AD_DATA;
        bus_oe_o  = 1'b0;
        bus_out_o = '0;
        case (state_q)
            A_SETUP, A_STROBE, A_HOLD: begin
                cs_n_o    = 1'b0;
                ad_o      = AD_ADDR;
                bus_oe_o  = 1'b1;
                bus_out_o = BUS_W'(addr_q);
                wr_n_o    = (state_q != A_STROBE);
            end
            D_SETUP, D_STROBE, D_HOLD: begin
                cs_n_o = 1'b0;
                ad_o   = AD_DATA;
                if (rw_q) begin
                    rd_n_o = (state_q != D_STROBE);
                end else begin
                    bus_oe_o  = 1'b1;
                    bus_out_o = BUS_W'(wdata_q);
                    wr_n_o    = (state_q != D_STROBE);
                end
            end
            default: ;
        endcase
    end

    assign grant_o = ((state_q == A_SETUP) && (cnt_q == '0)) ? win_q : '0;
    assign done_o  = (state_q == DONE) ? win_q : '0;
    assign busy_o  = (state_q != IDLE);
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Scoreboard bench: a fixed-priority and a round-robin instance, directed
// transactions with hand-derived cycle timing of strobes, grants and dones.
module tb_rtc_bus_arbiter;

    localparam int T   = 4;
    localparam int TXN = 6 * T + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic Reset;

    logic [3:0]  req_f, rw_f, grant_f, done_f;
    logic [31:0] addr_f, wdata_f;
    logic [7:0]  rdata_f, bus_out_f, bus_in_f;
    logic        busy_f, cs_n_f, rd_n_f, wr_n_f, ad_f, bus_oe_f;

    logic [3:0]  req_r, rw_r, grant_r, done_r;
    logic [31:0] addr_r, wdata_r;
    logic [7:0]  rdata_r, bus_out_r, bus_in_r;
    logic        busy_r, cs_n_r, rd_n_r, wr_n_r, ad_r, bus_oe_r;

    rtc_bus_arbiter #(.N_CLIENTS(4), .ADDR_W(8), .DATA_W(8), .T_PHASE(T), .ARB_MODE(0)) u_fix (
        .clk(clk), .Reset(Reset), .req_i(req_f), .rw_i(rw_f), .addr_i(addr_f),
        .wdata_i(wdata_f), .grant_o(grant_f), .done_o(done_f), .rdata_o(rdata_f),
        .busy_o(busy_f), .cs_n_o(cs_n_f), .rd_n_o(rd_n_f), .wr_n_o(wr_n_f), .ad_o(ad_f),
        .bus_out_o(bus_out_f), .bus_oe_o(bus_oe_f), .bus_in_i(bus_in_f)
    );

    rtc_bus_arbiter #(.N_CLIENTS(4), .ADDR_W(8), .DATA_W(8), .T_PHASE(T), .ARB_MODE(1)) u_rr (
        .clk(clk), .Reset(Reset), .req_i(req_r), .rw_i(rw_r), .addr_i(addr_r),
        .wdata_i(wdata_r), .grant_o(grant_r), .done_o(done_r), .rdata_o(rdata_r),
        .busy_o(busy_r), .cs_n_o(cs_n_r), .rd_n_o(rd_n_r), .wr_n_o(wr_n_r), .ad_o(ad_r),
        .bus_out_o(bus_out_r), .bus_oe_o(bus_oe_r), .bus_in_i(bus_in_r)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Scoreboard: stimulus pushes expectations, the monitor pops on DUT events.
    typedef struct packed {
        logic [3:0] oh;
        logic [7:0] rdata;
    } exp_done_t;

    logic [3:0] exp_grant_f[$];
    logic [3:0] exp_grant_r[$];
    exp_done_t  exp_done_f[$];
    exp_done_t  exp_done_r[$];
    exp_done_t  ed;
    int         last_f = -1;
    int         last_r = -1;

    always @(negedge clk) begin
        if (Reset) begin
            last_f = -1;
            last_r = -1;
        end
        if (grant_f != 4'b0) begin
            if (exp_grant_f.size() == 0) check("fix unexpected grant", 32'(grant_f), 32'd0);
            else check("fix grant", 32'(grant_f), 32'(exp_grant_f.pop_front()));
            if (last_f >= 0) check("fix grant spacing", 32'((cyc - last_f) >= TXN), 32'd1);
            last_f = cyc;
        end
        if (grant_r != 4'b0) begin
            if (exp_grant_r.size() == 0) check("rr unexpected grant", 32'(grant_r), 32'd0);
            else check("rr grant", 32'(grant_r), 32'(exp_grant_r.pop_front()));
            if (last_r >= 0) check("rr grant spacing", 32'((cyc - last_r) >= TXN), 32'd1);
            last_r = cyc;
        end
        if (done_f != 4'b0) begin
            if (exp_done_f.size() == 0) check("fix unexpected done", 32'(done_f), 32'd0);
            else begin
                ed = exp_done_f.pop_front();
                check("fix done client", 32'(done_f), 32'(ed.oh));
                check("fix rdata at done", 32'(rdata_f), 32'(ed.rdata));
            end
        end
        if (done_r != 4'b0) begin
            if (exp_done_r.size() == 0) check("rr unexpected done", 32'(done_r), 32'd0);
            else begin
                ed = exp_done_r.pop_front();
                check("rr done client", 32'(done_r), 32'(ed.oh));
                check("rr rdata at done", 32'(rdata_r), 32'(ed.rdata));
            end
        end
    end

    // Per-cycle trace of the fixed instance; cycle 0 is the cycle req is first driven.
    logic [3:0]  tr_grant[40], tr_done[40];
    logic [7:0]  tr_bus[40], tr_rdata[40];
    logic        tr_cs[40], tr_rd[40], tr_wr[40], tr_ad[40], tr_oe[40], tr_busy[40];
    logic [29:0] m_wr, m_rd, m_cs, m_busy, m_oe;
    int          first_grant, first_done;

    task automatic sample(input int c);
        tr_grant[c] = grant_f;  tr_done[c] = done_f;   tr_bus[c] = bus_out_f;
        tr_rdata[c] = rdata_f;  tr_cs[c]   = cs_n_f;   tr_rd[c]  = rd_n_f;
        tr_wr[c]    = wr_n_f;   tr_ad[c]   = ad_f;     tr_oe[c]  = bus_oe_f;
        tr_busy[c]  = busy_f;
    endtask

    task automatic build_masks();
        first_grant = -1;
        first_done  = -1;
        for (int c = 0; c < 30; c++) begin
            m_wr[c]   = !tr_wr[c];
            m_rd[c]   = !tr_rd[c];
            m_cs[c]   = !tr_cs[c];
            m_busy[c] = tr_busy[c];
            m_oe[c]   = tr_oe[c];
            if (first_grant < 0 && tr_grant[c] != 4'b0) first_grant = c;
            if (first_done < 0 && tr_done[c] != 4'b0) first_done = c;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_f || busy_r) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle within budget", 32'(n < 300), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset    = 1'b1;
        req_f    = '0;  rw_f    = '0;  addr_f = '0;  wdata_f = '0;  bus_in_f = 8'hEE;
        req_r    = '0;  rw_r    = '0;  addr_r = 32'h4433_2211;  wdata_r = 32'h8877_6655;
        bus_in_r = '0;
        repeat (3) @(posedge clk);

        // Reset values
        @(negedge clk);
        check("rst cs_n", 32'(cs_n_f), 32'd1);
        check("rst rd_n", 32'(rd_n_f), 32'd1);
        check("rst wr_n", 32'(wr_n_f), 32'd1);
        check("rst ad", 32'(ad_f), 32'd1);
        check("rst bus_oe", 32'(bus_oe_f), 32'd0);
        check("rst bus_out", 32'(bus_out_f), 32'd0);
        check("rst grant", 32'(grant_f), 32'd0);
        check("rst done", 32'(done_f), 32'd0);
        check("rst busy", 32'(busy_f), 32'd0);
        check("rst rdata", 32'(rdata_f), 32'd0);
        @(posedge clk); #1 Reset = 1'b0;
        @(posedge clk); #1;

        // T1: client 2 writes 0x45 to 0x21
        req_f = 4'b0100;  addr_f[16 +: 8] = 8'h21;  wdata_f[16 +: 8] = 8'h45;
        exp_grant_f.push_back(4'b0100);
        exp_done_f.push_back('{4'b0100, 8'h00});
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            sample(c);
            if (c == 1) req_f = 4'b0000;
        end
        build_masks();
        check("t1 grant cycle", 32'(first_grant), 32'd1);
        check("t1 done cycle", 32'(first_done), 32'd25);
        check("t1 wr_n low cycles", 32'(m_wr), 32'h001E_01E0);
        check("t1 rd_n low cycles", 32'(m_rd), 32'h0);
        check("t1 cs_n low cycles", 32'(m_cs), 32'h01FF_FFFE);
        check("t1 busy cycles", 32'(m_busy), 32'h03FF_FFFE);
        check("t1 bus_oe cycles", 32'(m_oe), 32'h01FF_FFFE);
        for (int c = 5; c <= 8; c++) begin
            check("t1 addr strobe bus", 32'(tr_bus[c]), 32'h21);
            check("t1 addr strobe ad", 32'(tr_ad[c]), 32'd0);
        end
        for (int c = 17; c <= 20; c++) begin
            check("t1 data strobe bus", 32'(tr_bus[c]), 32'h45);
            check("t1 data strobe ad", 32'(tr_ad[c]), 32'd1);
        end
        wait_idle();

        // T2: client 1 reads 0x22; only the last strobe cycle carries 0x37
        req_f = 4'b0010;  rw_f = 4'b0010;  addr_f[8 +: 8] = 8'h22;
        exp_grant_f.push_back(4'b0010);
        exp_done_f.push_back('{4'b0010, 8'h37});
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            sample(c);
            if (c == 1)  req_f = 4'b0000;
            if (c == 16) bus_in_f = 8'h30;
            if (c == 19) bus_in_f = 8'h37;
            if (c == 21) bus_in_f = 8'hEE;
        end
        build_masks();
        check("t2 grant cycle", 32'(first_grant), 32'd1);
        check("t2 done cycle", 32'(first_done), 32'd25);
        check("t2 rd_n low cycles", 32'(m_rd), 32'h001E_0000);
        check("t2 wr_n low cycles", 32'(m_wr), 32'h0000_01E0);
        check("t2 bus_oe cycles", 32'(m_oe), 32'h0000_1FFE);
        check("t2 addr bus", 32'(tr_bus[5]), 32'h22);
        check("t2 rdata before strobe", 32'(tr_rdata[16]), 32'h00);
        check("t2 rdata at done", 32'(tr_rdata[25]), 32'h37);
        wait_idle();

        // T3: req=1110 held on both instances
        rw_f = 4'b0000;
        req_f = 4'b1110;
        req_r = 4'b1110;
        repeat (3) begin
            exp_grant_f.push_back(4'b0010);
            exp_done_f.push_back('{4'b0010, 8'h37});
        end
        exp_grant_r.push_back(4'b0010);  exp_done_r.push_back('{4'b0010, 8'h00});
        exp_grant_r.push_back(4'b0100);  exp_done_r.push_back('{4'b0100, 8'h00});
        exp_grant_r.push_back(4'b1000);  exp_done_r.push_back('{4'b1000, 8'h00});
        exp_grant_r.push_back(4'b0010);  exp_done_r.push_back('{4'b0010, 8'h00});
        repeat (60) @(posedge clk);
        #1 req_f = 4'b0000;
        check("t3 fix grants consumed", 32'(exp_grant_f.size()), 32'd0);
        repeat (25) @(posedge clk);
        #1 req_r = 4'b0000;
        check("t3 rr grants consumed", 32'(exp_grant_r.size()), 32'd0);
        wait_idle();

        // T4: reset during A_HOLD of a client-3 write, then retry
        req_f = 4'b1000;  addr_f[24 +: 8] = 8'h33;  wdata_f[24 +: 8] = 8'h5A;
        exp_grant_f.push_back(4'b1000);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            sample(c);
            if (c == 10) Reset = 1'b1;
            if (c == 12) begin
                exp_grant_f.push_back(4'b1000);
                exp_done_f.push_back('{4'b1000, 8'h00});
                Reset = 1'b0;
            end
            if (c == 13) req_f = 4'b0000;
        end
        check("t4 in A_HOLD {cs_n,ad,busy}", 32'({tr_cs[10], tr_ad[10], tr_busy[10]}), 32'h1);
        check("t4 after reset {cs,rd,wr,busy,oe}",
              32'({tr_cs[11], tr_rd[11], tr_wr[11], tr_busy[11], tr_oe[11]}), 32'h1C);
        check("t4 no done after reset", 32'(tr_done[11]), 32'd0);
        check("t4 no grant in reset c11", 32'(tr_grant[11]), 32'd0);
        check("t4 no grant in reset c12", 32'(tr_grant[12]), 32'd0);
        check("t4 regrant after reset", 32'(tr_grant[13]), 32'h8);
        wait_idle();

        // T5: client 0 changes addr/wdata right after its grant
        req_f = 4'b0001;  addr_f[7:0] = 8'h10;  wdata_f[7:0] = 8'hAA;
        exp_grant_f.push_back(4'b0001);
        exp_done_f.push_back('{4'b0001, 8'h00});
        for (int c = 0; c < 27; c++) begin
            @(negedge clk);
            sample(c);
            if (c == 1) begin
                req_f       = 4'b0000;
                addr_f[7:0] = 8'h99;
                wdata_f[7:0] = 8'h55;
            end
        end
        for (int c = 1; c <= 12; c++) check("t5 addr phase bus", 32'(tr_bus[c]), 32'h10);
        for (int c = 13; c <= 24; c++) check("t5 data phase bus", 32'(tr_bus[c]), 32'hAA);
        wait_idle();

        // T6: Reset and req raised together
        Reset = 1'b1;
        req_f = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t6 no grant in reset", 32'(grant_f), 32'd0);
            check("t6 not busy in reset", 32'(busy_f), 32'd0);
        end
        exp_grant_f.push_back(4'b0010);
        exp_done_f.push_back('{4'b0010, 8'h00});
        Reset = 1'b0;
        begin
            int n = 0;
            while (grant_f == 4'b0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("t6 grant after reset release", 32'(grant_f), 32'h2);
        end
        req_f = 4'b0000;
        wait_idle();

        check("fix grants outstanding", 32'(exp_grant_f.size()), 32'd0);
        check("fix dones outstanding", 32'(exp_done_f.size()), 32'd0);
        check("rr grants outstanding", 32'(exp_grant_r.size()), 32'd0);
        check("rr dones outstanding", 32'(exp_done_r.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Parametrised arbiter and bus sequencer for the parallel RTC interface. It accepts read/write transactions from N clients (initialization, reset, write editor, permanent read, chronometer) and serialises them through one address/data multiplexed bus. It generates the chip-select, read, write and address-or-data strobes with configurable phase widths. It sits between the client state machines and the top-level tristate pad, and replaces ad-hoc address/data muxing with an explicit request/grant/done handshake.

## Interface
- N_CLIENTS, 4, number of requesters; client 0 has highest fixed priority
- ADDR_W, 8, RTC address width
- DATA_W, 8, RTC data width; bus width = max(ADDR_W, DATA_W)
- T_PHASE, 4, cycles per bus phase, >= 1
- ARB_MODE, 0, 0 = fixed priority, 1 = round-robin
- clk  in  1  clock
- Reset  in  1  synchronous, active-high
- req  in  N_CLIENTS  per-client request level
- rw  in  N_CLIENTS  per-client direction: 1 = read, 0 = write
- addr  in  N_CLIENTS*ADDR_W  packed client addresses, client i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_CLIENTS*DATA_W  packed client write data
- grant  out  N_CLIENTS  one-hot, one-cycle pulse; the command is latched in that cycle
- done  out  N_CLIENTS  one-hot, one-cycle pulse at transaction end
- rdata  out  DATA_W  last read data, held until the next read completes
- busy  out  1  high from grant until done, inclusive
- cs_n, rd_n, wr_n  out  1 each  RTC strobes, active-low
- ad  out  1  0 = address phase, 1 = data phase
- bus_out  out  bus width  value driven to the pad
- bus_oe  out  1  pad output enable
- bus_in  in  bus width  pad input

## Operation
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, DONE. Every state except IDLE and DONE lasts exactly T_PHASE cycles, counted by the phase counter.
- IDLE: if any req bit is set, select a winner, pulse grant[winner], latch rw/addr/wdata, then go to A_SETUP. If no req bit is set, stay in IDLE.
- Fixed mode: the lowest set index wins. Round-robin mode: search starts at the index after the last winner and wraps at N_CLIENTS-1 to 0. The pointer resets to N_CLIENTS-1, so client 0 wins first.
- Address phases: ad=0, bus_oe=1, bus_out = latched addr (zero-extended); wr_n=0 only in A_STROBE.
- Data phases: ad=1.
  - Write: bus_oe=1, bus_out = latched wdata; wr_n=0 only in D_STROBE.
  - Read: bus_oe=0; rd_n=0 only in D_STROBE; rdata captures bus_in[DATA_W-1:0] on the last D_STROBE cycle.
- cs_n=0 from A_SETUP through D_HOLD.
- DONE: one cycle; done[winner]=1 and all strobes are inactive. Next state is IDLE.
- req is level-sensitive. A client that still holds req after its done is re-arbitrated in the next IDLE.

## Timing
- Reset values: cs_n=rd_n=wr_n=1, ad=1, bus_oe=0, bus_out=0, grant=0, done=0, busy=0, rdata=0, state IDLE.
- Reset mid-transaction aborts immediately with no done pulse. Reset has priority over a simultaneous req.
- A req sampled in IDLE at edge k produces grant in cycle k+1 (first A_SETUP cycle).
- done rises 6*T_PHASE cycles after grant.
- Minimum grant-to-grant spacing is 6*T_PHASE+2 cycles.
- Changes to req, addr or wdata after the grant cycle have no effect on the current transaction.
- rdata changes only on a read's last D_STROBE cycle, and is stable when done pulses.
- Strobes never overlap:
  - wr_n and rd_n are never low together.
  - A phase change of ad never coincides with a strobe edge; SETUP and HOLD guard both sides.

## Structure
- Package rtc_bus_pkg holds the state enum, the AD_ADDR=0 and AD_DATA=1 constants, and the ARB_FIXED and ARB_RR constants.
- Sub-module rtc_arb_prio: combinational/registered winner select with round-robin pointer; inputs req and mode, outputs one-hot winner and valid.
- The sequencer state machine, phase counter and command latch live in the top of the block. The tristate buffer stays at the chip top.

## Test plan
- T_PHASE=4; client 2 writes addr 0x21, data 0x45 -> grant[2] at cycle 1; wr_n low cycles 5-8 with bus=0x21, ad=0, and cycles 17-20 with bus=0x45, ad=1; done[2] at cycle 25.
- Client 1 reads addr 0x22 with bus_in=0x37 during D_STROBE -> bus_oe=0 in data phases; rd_n low for 4 cycles; rdata=0x37 at done[1].
- Fixed mode, req=4'b1110 held -> grants in order 1, 1, 1 (client 1 monopolises). Round-robin mode, same req -> grants 1, 2, 3, 1.
- Reset asserted during A_HOLD -> the next cycle shows all strobes inactive, busy=0 and no done; a pending req is then granted after reset deasserts.
- Client 0 changes addr/wdata from 0x10/0xAA to 0x99/0x55 the cycle after grant -> the bus still shows 0x10/0xAA.
- Reset and req asserted in the same cycle -> no grant while Reset is high.
